multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequences one instruction at a time through FETCH → DECODE → EXECUTE → MEMORY → WRITEBACK.
- Drives IR load, PC update, ALU operand select, data-memory request/handshake and register-file write enable.
- Consumes the instruction-decoder outputs and the ALU compare result.
- Sits between the instruction/data memory interfaces and the datapath register/ALU stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 16, max wait cycles on a memory handshake before the trap flag is raised; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ready  in  1  data access complete this cycle
- read_status  in  2  decoder load size (DM_NONE = 2'b00)
- write_status  in  2  decoder store size (DM_NONE = 2'b00)
- write_back_type  in  2  decoder WB_NORMAL/WB_LOAD/WB_JAL
- change_branch_instruction  in  1  decoder branch/jump flag
- pc_for_input_a  in  1  decoder ALU-A select
- is_jal  in  1  opcode is JAL or JALR (unconditional)
- alu_cond  in  1  ALU compare result, bit 0
- destination_register_number  in  5  decoder rd
- ir_load  out  1  latch IR
- pc  out  32  current PC register
- pc_next_sel  out  2  0 = PC+4, 1 = ALU target, 2 = hold
- pc_write  out  1  update PC this cycle
- alu_a_sel  out  1  registered copy of pc_for_input_a
- reg_write  out  1  register-file write strobe
- reg_wb_sel  out  2  registered write_back_type
- state  out  3  current FSM state, for debug
- trap  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, rst_n = 0):
  - state = FETCH (3'd0); pc = RESET_PC.
  - All strobes (imem_req, dmem_req, dmem_we, ir_load, pc_write, reg_write) = 0.
  - pc_next_sel = 2; alu_a_sel = 0; reg_wb_sel = 0; trap = 0.
  - Reset asserted mid-transaction aborts it; no write strobe may glitch high.
- State encoding: FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, HALT = 5. Codes 6/7 go to FETCH on the next edge.
- FETCH:
  - imem_req = 1 until imem_ready.
  - On the imem_ready cycle: ir_load = 1 (one cycle, combinational); next state = DECODE.
- DECODE:
  - One cycle; decoder outputs are settled.
  - Register alu_a_sel, reg_wb_sel, read_status, write_status, change_branch_instruction, is_jal and rd.
  - Next state = EXECUTE.
- EXECUTE:
  - One cycle; sample alu_cond.
  - Next state = MEMORY if the registered read_status or write_status ≠ 0; otherwise WRITEBACK.
- MEMORY:
  - dmem_req = 1; dmem_we = (write_status ≠ 0).
  - Hold until dmem_ready.
  - Then: a store goes to WRITEBACK with no register write; a load goes to WRITEBACK.
- WRITEBACK:
  - One cycle.
  - reg_write = 1 iff rd ≠ 0 and the instruction is not a store and not a conditional branch (branch: change_branch = 1 and is_jal = 0).
  - pc_write = 1.
  - pc_next_sel = 1 if (change_branch and (is_jal or alu_cond)), else 0.
  - PC register updates at this edge: pc ← pc + 4 (wraps mod 2^32) for select 0; select 1 takes the datapath target, which arrives on input pc_target. Add port: pc_target  in  32.
  - Next state = FETCH.
- Instruction latency: 4 cycles for ALU/branch with zero-wait memory, 5 for load/store. Each wait cycle adds one.
- Timeout:
  - A counter counts consecutive cycles in FETCH or MEMORY without ready.
  - On reaching MEM_TIMEOUT: trap = 1 (sticky until reset), request dropped, state = HALT.
  - HALT holds all strobes at 0 forever.
- Ready arriving in the same cycle as the request is accepted (zero-wait). A ready outside FETCH/MEMORY is ignored.

Optional Feature:
- Macro CTRL_PERF_COUNTERS_EN.
- When defined: add outputs cycle_count[31:0] and instret_count[31:0], both reset to 0.
  - cycle_count increments every cycle except in HALT.
  - instret_count increments on every WRITEBACK cycle.
  - Both wrap at 2^32.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then addi with imem_ready tied 1 → ir_load at cycle 1, reg_write at cycle 4, pc 0→4.
- Load with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we = 0, reg_write once; total 8 cycles.
- Store (write_status = 2'b10) → dmem_we = 1, reg_write stays 0, pc += 4.
- beq with alu_cond = 1, pc_target = 32'h100 → pc_next_sel = 1, pc = 0x100; with alu_cond = 0 → pc = old + 4, reg_write = 0.
- pc = 32'hFFFF_FFFC, non-branch → pc wraps to 0. rd = 0 ALU op → reg_write stays 0.
- imem_ready held 0, MEM_TIMEOUT = 16 → trap = 1 after 16 cycles, state = 5. Then rst_n pulse low mid-MEMORY → state = 0, pc = RESET_PC, trap = 0 asynchronously.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with memory-handshake timeout trap.
// Optional cycle/instret counters are built when CTRL_PERF_COUNTERS_EN is defined.
module multicycle_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic [1:0]  read_status,
  input  logic [1:0]  write_status,
  input  logic [1:0]  write_back_type,
  input  logic        change_branch_instruction,
  input  logic        pc_for_input_a,
  input  logic        is_jal,
  input  logic        alu_cond,
  input  logic [4:0]  destination_register_number,
  input  logic [31:0] pc_target,
  output logic        ir_load,
  output logic [31:0] pc,
  output logic [1:0]  pc_next_sel,
  output logic        pc_write,
  output logic        alu_a_sel,
  output logic        reg_write,
  output logic [1:0]  reg_wb_sel,
  output logic [2:0]  state,
  output logic        trap
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  // states: 0 FETCH | 1 DECODE | 2 EXECUTE | 3 MEMORY | 4 WRITEBACK | 5 HALT (after timeout)
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
                         S_MEMORY = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam logic [31:0] TO_LOAD = (MEM_TIMEOUT == 0) ? 32'd0 : 32'(MEM_TIMEOUT - 1);

  logic [2:0]  r_state, w_state_nxt;
  logic [31:0] r_pc, r_wait_cnt;
  logic [1:0]  r_rd_status, r_wr_status, r_wb_sel;
  logic [4:0]  r_rd;
  logic        r_cb, r_jal, r_alu_cond, r_alu_a_sel, r_trap;
  logic        w_waiting, w_timeout, w_store, w_cond_branch;
  logic        w_imem_req, w_dmem_req, w_dmem_we, w_ir_load, w_pc_write, w_reg_write;
  logic [1:0]  w_pc_next_sel;

  assign w_waiting = ((r_state == S_FETCH) && !imem_ready) ||
                     ((r_state == S_MEMORY) && !dmem_ready);
  assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (r_wait_cnt == 32'd0);
  assign w_store       = (r_wr_status != 2'b00);
  assign w_cond_branch = r_cb && !r_jal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:   if (w_timeout) w_state_nxt = S_HALT;
                 else if (imem_ready) w_state_nxt = S_DECODE;
      S_DECODE:  w_state_nxt = S_EXECUTE;
      S_EXECUTE: w_state_nxt = ((r_rd_status != 2'b00) || w_store) ? S_MEMORY : S_WB;
      S_MEMORY:  if (w_timeout) w_state_nxt = S_HALT;
                 else if (dmem_ready) w_state_nxt = S_WB;
      S_WB:      w_state_nxt = S_FETCH;
      S_HALT:    w_state_nxt = S_HALT;
      default:   w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    w_imem_req    = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_ir_load     = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_pc_next_sel = 2'd2;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_load  = imem_ready;
      end
      S_MEMORY: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_store;
      end
      S_WB: begin
        w_pc_write    = 1'b1;
        w_reg_write   = (r_rd != 5'd0) && !w_store && !w_cond_branch;
        w_pc_next_sel = (r_cb && (r_jal || r_alu_cond)) ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
  end

  // Strobes are forced low while reset is held so nothing fires during an aborted transaction.
  assign imem_req    = rst_n & w_imem_req;
  assign dmem_req    = rst_n & w_dmem_req;
  assign dmem_we     = rst_n & w_dmem_we;
  assign ir_load     = rst_n & w_ir_load;
  assign pc_write    = rst_n & w_pc_write;
  assign reg_write   = rst_n & w_reg_write;
  assign pc_next_sel = w_pc_next_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_wait_cnt  <= TO_LOAD;
      r_rd_status <= 2'b00;
      r_wr_status <= 2'b00;
      r_wb_sel    <= 2'b00;
      r_rd        <= 5'd0;
      r_cb        <= 1'b0;
      r_jal       <= 1'b0;
      r_alu_cond  <= 1'b0;
      r_alu_a_sel <= 1'b0;
      r_trap      <= 1'b0;
    end else begin
      if (!w_waiting)              r_wait_cnt <= TO_LOAD;
      else if (r_wait_cnt != 32'd0) r_wait_cnt <= r_wait_cnt - 32'd1;
      if (r_state == S_DECODE) begin
        r_rd_status <= read_status;
        r_wr_status <= write_status;
        r_wb_sel    <= write_back_type;
        r_rd        <= destination_register_number;
        r_cb        <= change_branch_instruction;
        r_jal       <= is_jal;
        r_alu_a_sel <= pc_for_input_a;
      end
      if (r_state == S_EXECUTE) r_alu_cond <= alu_cond;
      if (w_pc_write) r_pc <= (w_pc_next_sel == 2'd1) ? pc_target : r_pc + 32'd4;
      if (w_timeout)  r_trap <= 1'b1;
    end
  end

  assign pc         = r_pc;
  assign alu_a_sel  = r_alu_a_sel;
  assign reg_wb_sel = r_wb_sel;
  assign state      = r_state;
  assign trap       = r_trap;

`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] r_cycle_cnt, r_instret_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      if (r_state != S_HALT) r_cycle_cnt   <= r_cycle_cnt + 32'd1;
      if (r_state == S_WB)   r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end
  assign cycle_count   = r_cycle_cnt;
  assign instret_count = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction mix, PC wrap, fetch timeout trap, async reset.
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [1:0]  read_status, write_status, write_back_type;
  logic        change_branch_instruction, pc_for_input_a, is_jal, alu_cond;
  logic [4:0]  destination_register_number;
  logic [31:0] pc_target;
  logic        ir_load, pc_write, alu_a_sel, reg_write, trap;
  logic [31:0] pc;
  logic [1:0]  pc_next_sel, reg_wb_sel;
  logic [2:0]  state;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  multicycle_controller #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .read_status(read_status), .write_status(write_status),
    .write_back_type(write_back_type),
    .change_branch_instruction(change_branch_instruction),
    .pc_for_input_a(pc_for_input_a), .is_jal(is_jal), .alu_cond(alu_cond),
    .destination_register_number(destination_register_number),
    .pc_target(pc_target),
    .ir_load(ir_load), .pc(pc), .pc_next_sel(pc_next_sel), .pc_write(pc_write),
    .alu_a_sel(alu_a_sel), .reg_write(reg_write), .reg_wb_sel(reg_wb_sel),
    .state(state), .trap(trap)
`ifdef CTRL_PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Step to just after the next rising edge; inputs set here apply to the new cycle.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [1:0] rs, input logic [1:0] ws, input logic [1:0] wb,
                         input logic cb, input logic jal, input logic pa, input logic [4:0] rd);
    read_status = rs; write_status = ws; write_back_type = wb;
    change_branch_instruction = cb; is_jal = jal; pc_for_input_a = pa;
    destination_register_number = rd;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0; alu_cond = 1'b0;
    pc_target = 32'h0;
    set_dec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    #12;
    chk("rst_state", state, 3'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_ir_load", ir_load, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_dmem_we", dmem_we, 1'b0);
    chk("rst_pc_write", pc_write, 1'b0);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_pc_next_sel", pc_next_sel, 2'd2);
    chk("rst_alu_a_sel", alu_a_sel, 1'b0);
    chk("rst_reg_wb_sel", reg_wb_sel, 2'd0);
    chk("rst_trap", trap, 1'b0);

    // addi rd=5, ALU A from PC
    adv(); rst_n = 1'b1; set_dec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd5); #1;
    chk("addi_c1_state", state, 3'd0);
    chk("addi_c1_ir_load", ir_load, 1'b1);
    chk("addi_c1_imem_req", imem_req, 1'b1);
    adv(); #1;
    chk("addi_c2_state", state, 3'd1);
    chk("addi_c2_ir_load", ir_load, 1'b0);
    adv(); #1;
    chk("addi_c3_state", state, 3'd2);
    chk("addi_c3_alu_a_sel", alu_a_sel, 1'b1);
    chk("addi_c3_reg_write", reg_write, 1'b0);
    adv(); set_dec(2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 5'd7); #1;
    chk("addi_c4_state", state, 3'd4);
    chk("addi_c4_reg_write", reg_write, 1'b1);
    chk("addi_c4_pc_write", pc_write, 1'b1);
    chk("addi_c4_pc_next_sel", pc_next_sel, 2'd0);

    // load rd=7, dmem_ready after 3 wait cycles
    adv(); #1;
    chk("ld_f_pc", pc, 32'h4);
    chk("ld_f_state", state, 3'd0);
    adv(); #1;
    chk("ld_d_state", state, 3'd1);
    adv(); #1;
    chk("ld_e_state", state, 3'd2);
    chk("ld_e_reg_wb_sel", reg_wb_sel, 2'd1);
    chk("ld_e_alu_a_sel", alu_a_sel, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      adv(); #1;
      chk("ld_mwait_state", state, 3'd3);
      chk("ld_mwait_dmem_req", dmem_req, 1'b1);
      chk("ld_mwait_dmem_we", dmem_we, 1'b0);
      chk("ld_mwait_reg_write", reg_write, 1'b0);
    end
    adv(); dmem_ready = 1'b1; #1;
    chk("ld_m4_state", state, 3'd3);
    chk("ld_m4_dmem_req", dmem_req, 1'b1);
    adv(); dmem_ready = 1'b0; set_dec(2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9); #1;
    chk("ld_wb_state", state, 3'd4);
    chk("ld_wb_reg_write", reg_write, 1'b1);
    chk("ld_wb_dmem_req", dmem_req, 1'b0);

    // store, zero-wait memory, rd field non-zero
    adv(); #1;
    chk("st_f_pc", pc, 32'h8);
    adv(); adv(); adv(); dmem_ready = 1'b1; #1;
    chk("st_m_state", state, 3'd3);
    chk("st_m_dmem_we", dmem_we, 1'b1);
    chk("st_m_dmem_req", dmem_req, 1'b1);
    adv(); dmem_ready = 1'b0; pc_target = 32'h100;
    set_dec(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'd3); #1;
    chk("st_wb_state", state, 3'd4);
    chk("st_wb_reg_write", reg_write, 1'b0);
    chk("st_wb_pc_next_sel", pc_next_sel, 2'd0);

    // beq taken
    adv(); #1;
    chk("beq1_f_pc", pc, 32'hC);
    adv(); adv(); alu_cond = 1'b1; #1;
    chk("beq1_e_state", state, 3'd2);
    adv(); alu_cond = 1'b0; #1;
    chk("beq1_wb_state", state, 3'd4);
    chk("beq1_wb_pc_next_sel", pc_next_sel, 2'd1);
    chk("beq1_wb_reg_write", reg_write, 1'b0);

    // beq not taken
    adv(); #1;
    chk("beq0_f_pc", pc, 32'h100);
    adv(); adv(); alu_cond = 1'b0; #1;
    adv(); pc_target = 32'hFFFF_FFFC;
    set_dec(2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 5'd1); #1;
    chk("beq0_wb_pc_next_sel", pc_next_sel, 2'd0);
    chk("beq0_wb_reg_write", reg_write, 1'b0);

    // jal rd=1 to 0xFFFF_FFFC with alu_cond low
    adv(); #1;
    chk("jal_f_pc", pc, 32'h104);
    adv(); adv(); adv(); #1;
    chk("jal_wb_pc_next_sel", pc_next_sel, 2'd1);
    chk("jal_wb_reg_write", reg_write, 1'b1);
    chk("jal_wb_reg_wb_sel", reg_wb_sel, 2'd2);
    set_dec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);

    // rd=0 ALU op at the top of the address space
    adv(); #1;
    chk("rd0_f_pc", pc, 32'hFFFF_FFFC);
    adv(); adv(); adv(); #1;
    chk("rd0_wb_reg_write", reg_write, 1'b0);
    chk("rd0_wb_pc_write", pc_write, 1'b1);
    set_dec(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd2);

    // addi after wrap, then load aborted by reset mid-MEMORY
    adv(); #1;
    chk("wrap_pc", pc, 32'h0);
    adv(); adv(); adv(); set_dec(2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 5'd4); #1;
    adv(); #1;
    chk("abort_f_pc", pc, 32'h4);
    adv(); adv(); adv(); #1;
    chk("abort_m_state", state, 3'd3);
    #2; rst_n = 1'b0; #1;
    chk("abort_state", state, 3'd0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_dmem_req", dmem_req, 1'b0);
    chk("abort_reg_write", reg_write, 1'b0);

    // fetch timeout: imem_ready held low for 16 cycles
    adv(); rst_n = 1'b1; imem_ready = 1'b0; #1;
    chk("to_w1_state", state, 3'd0);
    chk("to_w1_imem_req", imem_req, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      adv(); #1;
      chk("to_wait_state", state, 3'd0);
      chk("to_wait_trap", trap, 1'b0);
    end
    adv(); #1;
    chk("to_halt_state", state, 3'd5);
    chk("to_halt_trap", trap, 1'b1);
    chk("to_halt_imem_req", imem_req, 1'b0);
    adv(); imem_ready = 1'b1; #1;
    chk("halt_ir_load", ir_load, 1'b0);
    adv(); adv(); #1;
    chk("halt_hold_state", state, 3'd5);
    chk("halt_hold_trap", trap, 1'b1);
    chk("halt_hold_pc_write", pc_write, 1'b0);
    #2; rst_n = 1'b0; #1;
    chk("halt_rst_state", state, 3'd0);
    chk("halt_rst_trap", trap, 1'b0);
    chk("halt_rst_pc", pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
